// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the column-serial MixColumns stage: state in, transformed state out.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, inv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, inv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns over a 128-bit state, one 32-bit column per clock
// through a single shared column multiplier; result held until the consumer takes it.
module mix_columns_seq (
  input  logic               clk,
  input  logic               rst,
  mix_columns_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_reg;
  logic [1:0]   col_reg;
  logic [127:0] state_reg;
  logic [127:0] result_reg;
  logic         mode_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;

  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [7:0]   a  [4];
  logic [7:0]   m2 [4];
  logic [7:0]   m3 [4];
  logic [7:0]   m9 [4];
  logic [7:0]   mb [4];
  logic [7:0]   md [4];
  logic [7:0]   me [4];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    col_in = state_reg[127:96];
    case (col_reg)
      2'd0:    col_in = state_reg[127:96];
      2'd1:    col_in = state_reg[95:64];
      2'd2:    col_in = state_reg[63:32];
      default: col_in = state_reg[31:0];
    endcase
  end

  // Per-byte multiples, all derived from repeated xtime.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      logic [7:0] x2, x4, x8;
      assign a[gi]  = col_in[31-8*gi -: 8];
      assign x2     = xtime(a[gi]);
      assign x4     = xtime(x2);
      assign x8     = xtime(x4);
      assign m2[gi] = x2;
      assign m3[gi] = x2 ^ a[gi];
      assign m9[gi] = x8 ^ a[gi];
      assign mb[gi] = x8 ^ x2 ^ a[gi];
      assign md[gi] = x8 ^ x4 ^ a[gi];
      assign me[gi] = x8 ^ x4 ^ x2;
    end

    // Row r uses the circulant rotated by r: coefficients apply to a[r], a[r+1], a[r+2], a[r+3].
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign col_out[31-8*gi -: 8] = mode_reg
        ? (me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4])
        : (m2[gi] ^ m3[(gi+1)%4] ^ a[(gi+2)%4] ^ a[(gi+3)%4]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      col_reg       <= 2'd0;
      state_reg     <= 128'h0;
      result_reg    <= 128'h0;
      mode_reg      <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (bus.in_valid && in_ready_reg) begin
            state_reg    <= bus.in_data;
            mode_reg     <= bus.inv;
            col_reg      <= 2'd0;
            in_ready_reg <= 1'b0;
            fsm_reg      <= RUN;
          end
        end
        RUN: begin
          case (col_reg)
            2'd0:    result_reg[127:96] <= col_out;
            2'd1:    result_reg[95:64]  <= col_out;
            2'd2:    result_reg[63:32]  <= col_out;
            default: result_reg[31:0]   <= col_out;
          endcase
          col_reg <= col_reg + 2'd1;
          if (col_reg == 2'd3) begin
            out_valid_reg <= 1'b1;
            fsm_reg       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            fsm_reg       <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = result_reg;
endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: directed FIPS-197 columns, backpressure,
// mid-run reset, table-built round trips and back-to-back streaming.
module tb_mix_columns_seq;
  logic clk = 1'b0;
  logic rst;
  mix_columns_seq_if bus();

  mix_columns_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    string        name;
  } exp_t;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'h2d26314c_d4d4d4d5_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT   = 128'h4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6;
  localparam int NP = 11;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          acc_pend = 1'b0;
  logic        ov_prev = 1'b0;
  int          ready_mode = 1;
  logic [31:0] pre  [NP];
  logic [31:0] post [NP];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks first-result latency.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      acc_pend = 1'b0;
      ov_prev  = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev && acc_pend) begin
        check("latency", 128'(cyc - acc_cyc - 1), 128'd4);
        acc_pend = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_data);
        end else begin
          mon_e = sb_q.pop_front();
          check(mon_e.name, bus.out_data, mon_e.data);
          $display("out %s data=%h", mon_e.name, bus.out_data);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc  = cyc;
        acc_pend = 1'b1;
      end
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge with in_valid still high.
  task automatic send(input logic [127:0] d, input bit m, input logic [127:0] exp,
                      input string name, input int gap, output int acc);
    int   n;
    exp_t e;
    acc = -1;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inv      = m;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data = exp;
        e.name = name;
        sb_q.push_back(e);
        acc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout_%s actual=no_accept required=accept", name);
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev;
    int k;
    logic [127:0] s, f;

    pre[0]  = 32'hdb135345; post[0]  = 32'h8e4da1bc;
    pre[1]  = 32'hf20a225c; post[1]  = 32'h9fdc589d;
    pre[2]  = 32'h01010101; post[2]  = 32'h01010101;
    pre[3]  = 32'hc6c6c6c6; post[3]  = 32'hc6c6c6c6;
    pre[4]  = 32'hd4d4d4d5; post[4]  = 32'hd5d5d7d6;
    pre[5]  = 32'h2d26314c; post[5]  = 32'h4d7ebdf8;
    pre[6]  = 32'hd4bf5d30; post[6]  = 32'h046681e5;
    pre[7]  = 32'he0b452ae; post[7]  = 32'he0cb199a;
    pre[8]  = 32'hb84111f1; post[8]  = 32'h48f8d37a;
    pre[9]  = 32'h1e2798e5; post[9]  = 32'h2806264c;
    pre[10] = 32'h45454545; post[10] = 32'h45454545;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 128'h0;
    bus.inv      = 1'b0;
    ready_mode   = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(bus.in_ready), 128'd0);
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_out_data", bus.out_data, 128'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 128'(bus.in_ready), 128'd1);

    // Directed vectors.
    send(FIPS_IN, 1'b0, FIPS_OUT, "fips_fwd", 0, acc);
    send(FIPS_OUT, 1'b1, FIPS_IN, "fips_inv", 0, acc);
    send(V2_OUT, 1'b1, V2_IN, "v2_inv", 0, acc);
    send(V2_IN, 1'b0, V2_OUT, "v2_fwd", 0, acc);
    bus.in_valid = 1'b0;
    wait_drain();

    // Backpressure: inputs churn during RUN and DONE, result must follow captured inv=1.
    ready_mode = 0;
    send(FIPS_OUT, 1'b1, FIPS_IN, "bp_inv", 0, acc);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_data  = {4{$urandom()}};
      bus.inv      = ~bus.inv;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_out_data", bus.out_data, FIPS_IN);
      bus.in_valid = ~bus.in_valid;
      bus.in_data  = {4{$urandom()}};
      bus.inv      = ~bus.inv;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    ready_mode   = 1;
    @(posedge clk);
    #1;
    check("bp_in_ready_return", 128'(bus.in_ready), 128'd1);
    check("bp_out_valid_drop", 128'(bus.out_valid), 128'd0);
    wait_drain();

    // Reset while the third column is being processed.
    send(FIPS_IN, 1'b0, FIPS_OUT, "aborted", 0, acc);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst_out_data", bus.out_data, 128'h0);
    check("midrst_in_ready", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready_after", 128'(bus.in_ready), 128'd1);
    send(V2_OUT, 1'b1, V2_IN, "post_rst", 0, acc);
    bus.in_valid = 1'b0;
    wait_drain();

    // Round trips on states assembled from known column pairs, random gaps.
    ready_mode = 2;
    for (int v = 0; v < 20; v++) begin
      s = 128'h0;
      f = 128'h0;
      for (int c = 0; c < 4; c++) begin
        k = int'($urandom_range(0, NP - 1));
        s[127-32*c -: 32] = pre[k];
        f[127-32*c -: 32] = post[k];
      end
      send(s, 1'b0, f, $sformatf("rt_fwd%0d", v), int'($urandom_range(0, 3)), acc);
      send(f, 1'b1, s, $sformatf("rt_inv%0d", v), int'($urandom_range(0, 3)), acc);
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // Streaming with in_valid and out_ready held high.
    ready_mode = 1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      s = {pre[i], pre[i+1], pre[i+2], pre[i+3]};
      f = {post[i], post[i+1], post[i+2], post[i+3]};
      if (i % 2 == 0)
        send(s, 1'b0, f, $sformatf("stream%0d", i), 0, acc);
      else
        send(f, 1'b1, s, $sformatf("stream%0d", i), 0, acc);
      if (i > 0) check("stream_period", 128'(acc - prev), 128'd6);
      prev = acc;
    end
    bus.in_valid = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
